// File: rtl/wb_char_printer_pkg.sv
// Shared register map, STATUS field positions and printer FSM states.
// No logic; constants and types only.
// Imported by the character printer top level.
package printer_pkg;

    localparam logic [2:0] REG_DATA   = 3'h0;
    localparam logic [2:0] REG_STATUS = 3'h4;

    localparam int ST_EMPTY_BIT = 8;
    localparam int ST_FULL_BIT  = 9;
    localparam int ST_BUSY_BIT  = 10;
    localparam int ST_OVF_BIT   = 11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } prn_state_e;

endpackage

// File: rtl/wb_char_printer_fifo.sv
// Generic synchronous FIFO with level, full and empty flags.
// Push visible on the output one cycle later; head read combinationally.
// Push when full and pop when empty are ignored; the caller decides policy.
module printer_fifo #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_dat_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [AW:0]       level_o
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              push_ok, pop_ok;

    assign full_o    = (level_q == (AW + 1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign push_ok   = push_i & ~full_o;
    assign pop_ok    = pop_i & ~empty_o;

    // Pointer and level next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset since level gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/wb_char_printer.sv
// Wishbone-fed character printer: buffers bytes and replays them on mprj_io[7:0] with a paced strobe.
// Ack one cycle after a hit; each byte occupies 1+SETUP+STROBE+HOLD cycles on the pads.
// Full FIFO drops and flags overflow; with PRINTER_BACKPRESSURE_EN defined the write ack is held until space frees.
module wb_char_printer #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0100,
    parameter int          DEPTH      = 16,
    parameter int          SETUP_CYC  = 4,
    parameter int          STROBE_CYC = 4,
    parameter int          HOLD_CYC   = 4
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [7:0]  io_data_o,
    output logic        io_strobe_o,
    output logic [7:0]  io_oeb_o
);

    import printer_pkg::*;

    localparam int LVL_W   = $clog2(DEPTH) + 1;
    localparam int MAX_CYC = (SETUP_CYC > STROBE_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Wishbone side
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  oeb_q, oeb_d;
    logic        wb_hit, sel_data, sel_status;
    logic        data_wr, status_rd, status_wr;
    logic        push, wr_stall, ovf_set;
    logic [31:0] status_word;

    // FIFO
    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic             fifo_full, fifo_empty;
    logic [LVL_W-1:0] fifo_level;

    // Printer FSM
    prn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       data_q, data_d;
    logic             strobe_q, strobe_d;

    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i[3:1], wbs_dat_i[31:12], wbs_dat_i[10:8]};

    // A held request is not re-evaluated in the ack cycle, so one request gets one ack.
    assign wb_hit     = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:3] == BASE_ADDR[31:3]) & ~ack_q;
    assign sel_data   = (wbs_adr_i[2:0] == REG_DATA);
    assign sel_status = (wbs_adr_i[2:0] == REG_STATUS);
    assign data_wr    = wb_hit & wbs_we_i & sel_data & wbs_sel_i[0];
    assign status_rd  = wb_hit & ~wbs_we_i & sel_status;
    assign status_wr  = wb_hit & wbs_we_i & sel_status;
    assign push       = data_wr & ~fifo_full;

`ifdef PRINTER_BACKPRESSURE_EN
    assign wr_stall = data_wr & fifo_full;
    assign ovf_set  = 1'b0;
`else
    assign wr_stall = 1'b0;
    assign ovf_set  = data_wr & fifo_full;
`endif

    // STATUS word assembled from live FIFO and FSM state.
    always_comb begin
        status_word               = '0;
        status_word[7:0]          = 8'(fifo_level);
        status_word[ST_EMPTY_BIT] = fifo_empty;
        status_word[ST_FULL_BIT]  = fifo_full;
        status_word[ST_BUSY_BIT]  = (state_q != IDLE);
        status_word[ST_OVF_BIT]   = ovf_q;
    end

    // Bus response, sticky overflow and pad enable next-state.
    always_comb begin
        ack_d = wb_hit & ~wr_stall;
        dat_d = status_rd ? status_word : 32'h0;
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (status_wr && wbs_dat_i[ST_OVF_BIT]) begin
            ovf_d = 1'b0;
        end
        oeb_d = push ? 8'h00 : oeb_q;
    end

    // Bus-side registers.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            ack_q <= 1'b0;
            dat_q <= 32'h0;
            ovf_q <= 1'b0;
            oeb_q <= 8'hFF;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            ovf_q <= ovf_d;
            oeb_q <= oeb_d;
        end
    end

    printer_fifo #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i      (clock),
        .rst_ni     (resetb),
        .push_i     (push),
        .push_dat_i (wbs_dat_i[7:0]),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    // Printer sequencing: pop, setup, strobe, hold, sharing one down-counter.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    data_d   = fifo_head;
                    state_d  = SETUP;
                    cnt_d    = SETUP_LD;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d  = STROBE;
                    strobe_d = 1'b1;
                    cnt_d    = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d  = HOLD;
                    strobe_d = 1'b0;
                    cnt_d    = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d  = IDLE;
                strobe_d = 1'b0;
            end
        endcase
    end

    // Printer registers; reset drops strobe and data immediately.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= 8'h00;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = dat_q;
    assign io_data_o   = data_q;
    assign io_strobe_o = strobe_q;
    assign io_oeb_o    = oeb_q;

endmodule

// File: tb/tb_wb_char_printer.sv
// Self-checking bench for wb_char_printer against a queue-based reference model.
// Model steps on each clock edge; checks are made on the falling edge.
// Writes hold the request until ack or a cycle bound expires.
module tb_wb_char_printer;

    localparam logic [31:0] BASE     = 32'h3000_0100;
    localparam int          DEPTH    = 16;
    localparam int          SETUP    = 4;
    localparam int          STRB     = 4;
    localparam int          HOLD     = 4;
    localparam int          BUSY_CYC = SETUP + STRB + HOLD;

    logic        clock = 1'b0;
    logic        resetb = 1'b0;
    logic        wbs_cyc_i = 1'b0;
    logic        wbs_stb_i = 1'b0;
    logic        wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = 32'h0;
    logic [31:0] wbs_dat_i = 32'h0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [7:0]  io_data_o;
    logic        io_strobe_o;
    logic [7:0]  io_oeb_o;

    always #5 clock = ~clock;

    wb_char_printer dut (
        .clock       (clock),
        .resetb      (resetb),
        .wbs_cyc_i   (wbs_cyc_i),
        .wbs_stb_i   (wbs_stb_i),
        .wbs_we_i    (wbs_we_i),
        .wbs_sel_i   (wbs_sel_i),
        .wbs_adr_i   (wbs_adr_i),
        .wbs_dat_i   (wbs_dat_i),
        .wbs_ack_o   (wbs_ack_o),
        .wbs_dat_o   (wbs_dat_o),
        .io_data_o   (io_data_o),
        .io_strobe_o (io_strobe_o),
        .io_oeb_o    (io_oeb_o)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  mq[$];
    int          m_rem = 0;
    int          m_pops = 0;
    logic [7:0]  m_data = 8'h00;
    logic [7:0]  m_oeb = 8'hFF;
    logic        m_ack = 1'b0;
    logic        m_ovf = 1'b0;
    logic [31:0] m_dat = 32'h0;

    always @(posedge clock or negedge resetb) begin : ref_model
        logic        hit, is_full, push, n_ack;
        logic [31:0] status, n_dat;
        if (!resetb) begin
            mq.delete();
            m_rem  = 0;
            m_data = 8'h00;
            m_oeb  = 8'hFF;
            m_ack  = 1'b0;
            m_ovf  = 1'b0;
            m_dat  = 32'h0;
        end else begin
            hit     = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:3] == BASE[31:3]) && !m_ack;
            is_full = (mq.size() == DEPTH);
            status  = {20'd0, m_ovf, (m_rem != 0), is_full, (mq.size() == 0), 8'(mq.size())};
            push    = 1'b0;
            n_ack   = hit;
            n_dat   = 32'h0;
            if (hit && wbs_we_i && wbs_adr_i[2:0] == 3'h0 && wbs_sel_i[0]) begin
                if (!is_full) push = 1'b1;
`ifdef PRINTER_BACKPRESSURE_EN
                else n_ack = 1'b0;
`else
                else m_ovf = 1'b1;
`endif
            end
            if (hit && !wbs_we_i && wbs_adr_i[2:0] == 3'h4) n_dat = status;
            if (hit && wbs_we_i && wbs_adr_i[2:0] == 3'h4 && wbs_dat_i[11]) m_ovf = 1'b0;
            if (m_rem == 0 && mq.size() != 0) begin
                m_data = mq.pop_front();
                m_rem  = BUSY_CYC;
                m_pops++;
            end else if (m_rem != 0) begin
                m_rem--;
            end
            if (push) begin
                mq.push_back(wbs_dat_i[7:0]);
                m_oeb = 8'h00;
            end
            m_ack = n_ack;
            m_dat = n_dat;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (resetb) begin
            chk("ack", wbs_ack_o, m_ack);
            chk("rdata", wbs_dat_o, m_dat);
            chk("io_data", io_data_o, m_data);
            chk("io_strobe", io_strobe_o, (m_rem > HOLD && m_rem <= HOLD + STRB));
            chk("io_oeb", io_oeb_o, m_oeb);
        end
    end

    // Strobe rising-edge monitor, as the character monitor would see it.
    int         cyc_cnt = 0;
    logic       strobe_prev = 1'b0;
    logic [7:0] rise_dat[$];
    int         rise_cyc[$];

    always @(posedge clock) cyc_cnt++;

    always @(negedge clock) begin
        if (resetb && io_strobe_o && !strobe_prev) begin
            rise_dat.push_back(io_data_o);
            rise_cyc.push_back(cyc_cnt);
        end
        strobe_prev = resetb ? io_strobe_o : 1'b0;
    end

    // ---------------- bus tasks ----------------
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int bound,
                        output logic got, output logic [31:0] rdat);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        got  = 1'b0;
        rdat = 32'h0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clock);
            if (wbs_ack_o === 1'b1) begin
                got  = 1'b1;
                rdat = wbs_dat_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        logic        got;
        logic [31:0] rd;
        xfer(1'b1, adr, dat, sel, 40, got, rd);
        chk("wr_ack", got, 1'b1);
    endtask

    task automatic rd_status(output logic [31:0] d);
        logic got;
        xfer(1'b0, BASE + 32'h4, 32'h0, 4'hF, 40, got, d);
        chk("rd_ack", got, 1'b1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 3000 && (mq.size() != 0 || m_rem != 0); i++) @(negedge clock);
        if (i == 3000) begin
            miscompares++;
            $error("FAIL drain_timeout observed=busy expected=idle");
        end
        @(negedge clock);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [31:0] st;
        logic        got;
        logic [31:0] rd;
        int          base_pops;
        int          i;
        logic [7:0]  exp_chars[3];

        // Reset values
        #12;
        chk("rst_ack", wbs_ack_o, 1'b0);
        chk("rst_rdata", wbs_dat_o, 32'h0);
        chk("rst_data", io_data_o, 8'h00);
        chk("rst_strobe", io_strobe_o, 1'b0);
        chk("rst_oeb", io_oeb_o, 8'hFF);
        @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        rd_status(st);
        chk("rst_status", st, 32'h0000_0100);

        // Three characters, 13 cycles apart
        rise_dat.delete();
        rise_cyc.delete();
        wr(BASE, 32'h48, 4'h1);
        chk("oeb_after_first", io_oeb_o, 8'h00);
        wr(BASE, 32'h69, 4'h1);
        wr(BASE, 32'h04, 4'h1);
        for (i = 0; i < 100 && rise_dat.size() < 3; i++) @(negedge clock);
        if (rise_dat.size() >= 3) begin
            exp_chars[0] = 8'h48;
            exp_chars[1] = 8'h69;
            exp_chars[2] = 8'h04;
            for (int k = 0; k < 3; k++) chk("char", rise_dat[k], exp_chars[k]);
            chk("gap01", rise_cyc[1] - rise_cyc[0], 1 + BUSY_CYC);
            chk("gap12", rise_cyc[2] - rise_cyc[1], 1 + BUSY_CYC);
        end else begin
            miscompares++;
            $error("FAIL strobe_timeout observed=%0d expected=3", rise_dat.size());
        end
        drain();

        // STATUS while the first of three bytes is being printed
        wr(BASE, 32'h31, 4'h1);
        wr(BASE, 32'h32, 4'h1);
        wr(BASE, 32'h33, 4'h1);
        rd_status(st);
        chk("st3_level", st[7:0], 8'd2);
        chk("st3_busy", st[10], 1'b1);
        chk("st3_empty", st[8], 1'b0);
        drain();

        // Burst past capacity
        base_pops = m_pops;
        rise_dat.delete();
        for (int k = 0; k < 24; k++) wr(BASE, 32'h40 + k, 4'h1);
        rd_status(st);
`ifdef PRINTER_BACKPRESSURE_EN
        chk("ovf_bp", st[11], 1'b0);
`else
        chk("ovf_set", st[11], 1'b1);
`endif
        wr(BASE + 32'h4, 32'h800, 4'hF);
        rd_status(st);
        chk("ovf_clear", st[11], 1'b0);
        drain();
        chk("burst_chars", rise_dat.size(), m_pops - base_pops);

        // sel[0]=0 write is acked without a push
        wr(BASE, 32'hAA, 4'hE);
        rd_status(st);
        chk("nosel_level", st[7:0], 8'd0);

        // Out-of-window accesses
        wr(BASE, 32'h5A, 4'h1);
        xfer(1'b1, BASE + 32'h10, 32'h77, 4'h1, 8, got, rd);
        chk("miss_noack", got, 1'b0);
        xfer(1'b0, BASE - 32'h8, 32'h0, 4'hF, 8, got, rd);
        chk("miss_rd_noack", got, 1'b0);
        drain();

        // Randomised traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: wr(BASE, 32'($urandom_range(0, 255)), 4'($urandom));
                6: rd_status(st);
                7: wr(BASE + 32'h4, $urandom, 4'hF);
                8: begin
                    xfer(1'b1, BASE ^ (32'h1 << $urandom_range(3, 31)), $urandom, 4'hF, 4, got, rd);
                    chk("rand_miss", got, 1'b0);
                end
                default: repeat ($urandom_range(0, 15)) @(negedge clock);
            endcase
        end
        drain();

        // Reset in the middle of a strobe
        wr(BASE, 32'h55, 4'h1);
        for (i = 0; i < 40 && m_rem != HOLD + 2; i++) @(negedge clock);
        chk("strobe_before_rst", io_strobe_o, 1'b1);
        #2;
        resetb = 1'b0;
        #1;
        chk("arst_strobe", io_strobe_o, 1'b0);
        chk("arst_data", io_data_o, 8'h00);
        chk("arst_oeb", io_oeb_o, 8'hFF);
        @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        rd_status(st);
        chk("post_rst_status", st, 32'h0000_0100);
        repeat (4) @(negedge clock);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_char_printer.md
Name: wb_char_printer

Overview:
- Wishbone slave in the user project area. Firmware writes bytes to it, the block buffers them in a FIFO, then replays them on mprj_io[7:0] with a paced strobe.
- The strobe is the signal the testbench monitor samples on its rising edge to build printf output; byte 0x04 marks end of test.
- Sits between the management SoC Wishbone bus and the GPIO pads; it is the producer stage for the bench's character monitor.

Parameters:
- BASE_ADDR, 32'h3000_0100, byte address of register block; decode on adr[31:3].
- DEPTH, 16, FIFO entries; power of two, >= 2.
- SETUP_CYC, 4, cycles data is stable before strobe rises (>= 1).
- STROBE_CYC, 4, cycles strobe is held high (>= 1).
- HOLD_CYC, 4, cycles data is held after strobe falls (>= 1).

Ports:
- clock  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- io_data_o  out  8  character onto mprj_io[7:0]
- io_strobe_o  out  1  character-valid strobe (drives gpio)
- io_oeb_o  out  8  pad output-enable, active-low

Behaviour:
- Reset values: wbs_ack_o=0, wbs_dat_o=0, io_data_o=0, io_strobe_o=0, io_oeb_o=8'hFF, FIFO empty, overflow flag cleared, FSM in IDLE. Reset mid-byte aborts the byte immediately with no partial strobe.
- Address decode: hit = cyc & stb & (adr[31:3]==BASE_ADDR[31:3]). Offset 0x0 is DATA; offset 0x4 is STATUS. Accesses that miss are ignored and get no ack.
- Ack timing: registered. wbs_ack_o rises the cycle after a hit and lasts 1 cycle. No back-to-back ack for the same held request: ack suppresses the next hit evaluation for one cycle.
- DATA write with sel[0]=1: pushes dat_i[7:0]. sel[0]=0: acked, no push. DATA read returns 0.
- STATUS read fields:
  - [7:0] FIFO level
  - [8] empty
  - [9] full
  - [10] busy (FSM not IDLE)
  - [11] sticky overflow
  - rest 0
- STATUS write with dat_i[11]=1: clears overflow. Other bits ignored.
- Full FIFO (default, macro absent): push is dropped, overflow set, write still acked.
- Simultaneous push and pop in the same cycle: both take effect, level unchanged. Push into an empty FIFO while IDLE is visible to the FSM next cycle.
- io_oeb_o: driven to 8'h00 on the first push after reset and stays there. This is the only change to it.
- FSM, with a single counter whose width fits max(SETUP,STROBE,HOLD)_CYC:
  - IDLE: FIFO not empty -> pop head into io_data_o, go SETUP, counter=SETUP_CYC-1.
  - SETUP: counter 0 -> STROBE, io_strobe_o=1.
  - STROBE: counter 0 -> HOLD, io_strobe_o=0.
  - HOLD: counter 0 -> IDLE.
  - io_data_o is constant from pop until the next pop.
  - Per-byte period = 1+SETUP+STROBE+HOLD cycles = 13 at defaults.
- Level counter is width clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro PRINTER_BACKPRESSURE_EN.
- Defined: a DATA write to a full FIFO holds ack low until a pop frees space, then pushes and acks. Overflow never sets; STATUS[11] reads 0.
- Undefined: drop-and-flag behaviour as above.

Decomposition:
- Package printer_pkg holds: register offsets (REG_DATA=3'h0, REG_STATUS=3'h4), STATUS bit indices, FSM state enum (IDLE, SETUP, STROBE, HOLD).
- One sub-module, printer_fifo: synchronous FIFO with push/pop/full/empty/level and async active-low reset. The top level holds decode, registers and the FSM.

Test Plan:
- Write 0x48,0x69,0x04 to DATA -> three strobe rising edges with io_data_o 0x48,0x69,0x04 at each edge, 13 cycles apart. io_oeb_o=0x00 after the first write.
- Write 17 bytes back-to-back with the FSM stalled at reset defaults -> 17th byte dropped, STATUS[11]=1, all 17 writes acked. Write 0x800 to STATUS -> [11]=0.
- With PRINTER_BACKPRESSURE_EN, the same 17 writes -> 17th ack delayed until the first pop, all 17 bytes emitted in order.
- Read STATUS after 3 pushes while the first byte is in SETUP -> level=2, busy=1, empty=0.
- Access address BASE_ADDR+0x10 -> no ack within 8 cycles, FIFO unchanged.
- Deassert resetb during STROBE -> io_strobe_o=0, io_data_o=0 asynchronously. STATUS reads empty after reset release.
